// File: rtl/sum_pwm_driver_if.sv
// Duty-value handshake between the operand-sum stage and the PWM driver.
// The upstream stage is the master: it offers in_data/in_valid and sees in_ready.
interface sum_pwm_driver_if #(
   parameter int unsigned WIDTH = 8
) ();

   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );

endinterface

// File: rtl/sum_pwm_driver.sv
// PWM LED driver fed by the operand-sum stage.
// Each accepted sum becomes a duty value. It is double-buffered in a pending slot and
// only promoted to the active duty on the last step of a PWM period, so the waveform
// never glitches mid-period.
module sum_pwm_driver #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   sum_pwm_driver_if.slave  in_bus,
   output logic             pwm_out,
   output logic             period_start,
   output logic [WIDTH-1:0] duty_active
);

   // A one-bit prescaler is kept even for PRESCALE == 1; it then simply stays at zero.
   localparam int unsigned   PsWidth = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PsWidth-1:0] PsLast  = PsWidth'(PRESCALE - 1);

   logic [PsWidth-1:0] presc_q, presc_d;
   logic [WIDTH-1:0]   cnt_q, cnt_d;
   logic               pend_valid_q, pend_valid_d;
   logic [WIDTH-1:0]   pend_duty_q, pend_duty_d;
   logic [WIDTH-1:0]   duty_q, duty_d;
   logic               pwm_q, pwm_d;
   logic               pstart_q, pstart_d;

   logic               tick;
   logic               boundary;
   logic               xfer;

   // Period timing: step tick from the prescaler, boundary on the last step of a period.
   always_comb begin
      tick     = (presc_q == PsLast);
      boundary = tick && (cnt_q == {WIDTH{1'b1}});
   end

   // Ready depends only on registers, so upstream never sees a combinational loop.
   always_comb begin
      in_bus.in_ready = !pend_valid_q || boundary;
      xfer            = in_bus.in_valid && in_bus.in_ready;
   end

   // Prescaler and PWM step counter next state; both wrap naturally.
   always_comb begin
      presc_d = presc_q;
      cnt_d   = cnt_q;
      if (tick) begin
         presc_d = '0;
         cnt_d   = cnt_q + 1'b1;
      end else begin
         presc_d = presc_q + 1'b1;
      end
   end

   // Double buffer: new data always lands in the pending slot first, and the slot is
   // promoted to the active duty only at a boundary.
   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_duty_d  = pend_duty_q;
      duty_d       = duty_q;
      if (boundary && pend_valid_q) begin
         duty_d = pend_duty_q;
      end
      if (xfer) begin
         pend_duty_d  = in_bus.in_data;
         pend_valid_d = 1'b1;
      end else if (boundary) begin
         pend_valid_d = 1'b0;
      end
   end

   // Output stage: registered compare (one cycle behind cnt) and period-start pulse.
   always_comb begin
      pwm_d    = (cnt_q < duty_q);
      pstart_d = boundary;
   end

   // State registers with asynchronous clear; a pending duty is dropped on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q      <= '0;
         cnt_q        <= '0;
         pend_valid_q <= 1'b0;
         pend_duty_q  <= '0;
         duty_q       <= '0;
         pwm_q        <= 1'b0;
         pstart_q     <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         cnt_q        <= cnt_d;
         pend_valid_q <= pend_valid_d;
         pend_duty_q  <= pend_duty_d;
         duty_q       <= duty_d;
         pwm_q        <= pwm_d;
         pstart_q     <= pstart_d;
      end
   end

   // Drive the outputs straight from the registers.
   always_comb begin
      pwm_out      = pwm_q;
      period_start = pstart_q;
      duty_active  = duty_q;
   end

endmodule

// File: tb/tb_sum_pwm_driver.sv
// Self-checking bench for sum_pwm_driver.
// The reference model tracks time as a cycle count since reset release and derives the
// PWM step, boundary and handshake from that count arithmetically.
module tb_sum_pwm_driver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pwm1, ps1, pwm4, ps4;
   logic [7:0] da1, da4;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state (PRESCALE = 1 instance).
   int unsigned mcyc;
   int          m_duty;
   int          m_pd;
   logic        m_pv;

   sum_pwm_driver_if #(.WIDTH(8)) bus1 ();
   sum_pwm_driver_if #(.WIDTH(8)) bus4 ();

   sum_pwm_driver #(.WIDTH(8), .PRESCALE(1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_bus       (bus1),
      .pwm_out      (pwm1),
      .period_start (ps1),
      .duty_active  (da1)
   );

   sum_pwm_driver #(.WIDTH(8), .PRESCALE(4)) dut4 (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_bus       (bus4),
      .pwm_out      (pwm4),
      .period_start (ps4),
      .duty_active  (da4)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic mreset();
      mcyc   = 0;
      m_duty = 0;
      m_pd   = 0;
      m_pv   = 1'b0;
   endtask

   // One clock: drive inputs, check ready, advance model and DUT, check outputs.
   task automatic cycle(input logic v, input logic [7:0] d, output logic acc);
      int   cnt;
      logic bnd, exp_rdy, e_pwm, e_ps;
      bus1.in_valid = v;
      bus1.in_data  = d;
      #1;
      cnt     = int'(mcyc % 256);
      bnd     = (cnt == 255);
      exp_rdy = !m_pv || bnd;
      check("in_ready", {31'd0, bus1.in_ready}, {31'd0, exp_rdy});
      acc   = v && exp_rdy;
      e_pwm = (cnt < m_duty);
      e_ps  = bnd;
      if (bnd && m_pv) m_duty = m_pd;
      if (acc) begin
         m_pd = int'(d);
         m_pv = 1'b1;
      end else if (bnd) begin
         m_pv = 1'b0;
      end
      @(posedge clk);
      mcyc++;
      #1;
      check("pwm_out", {31'd0, pwm1}, {31'd0, e_pwm});
      check("period_start", {31'd0, ps1}, {31'd0, e_ps});
      check("duty_active", {24'd0, da1}, m_duty);
   endtask

   task automatic idle();
      logic a;
      cycle(1'b0, 8'd0, a);
   endtask

   // Run until the model sits on the first cycle of the next period.
   task automatic to_period_start();
      idle();
      while (mcyc % 256 != 0) idle();
   endtask

   // Run one full period from its first cycle and profile the PWM output.
   task automatic count_period(output int hi, output int first_hi, output int last_hi,
                               output int last_lo);
      hi = 0; first_hi = -1; last_hi = -1; last_lo = -1;
      for (int i = 0; i < 256; i++) begin
         idle();
         if (pwm1) begin
            hi++;
            if (first_hi < 0) first_hi = i;
            last_hi = i;
         end else begin
            last_lo = i;
         end
      end
   endtask

   initial begin
      logic acc, last_bnd, hold, v;
      logic [7:0] d;
      int hi, fh, lh, ll, hi4, npulse;
      int pulses[8];

      bus1.in_valid = 1'b0;
      bus1.in_data  = '0;
      bus4.in_valid = 1'b0;
      bus4.in_data  = '0;
      mreset();

      // Reset held: outputs cleared, ready high.
      @(posedge clk);
      @(posedge clk);
      #2;
      check("rst_pwm", {31'd0, pwm1}, 0);
      check("rst_pstart", {31'd0, ps1}, 0);
      check("rst_duty", {24'd0, da1}, 0);
      check("rst_ready", {31'd0, bus1.in_ready}, 1);
      check("rst_ready4", {31'd0, bus4.in_ready}, 1);
      check("rst_duty4", {24'd0, da4}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mreset();

      // Single load of 64 at cnt=10.
      for (int i = 0; i < 10; i++) idle();
      cycle(1'b1, 8'd64, acc);
      check("t2_acc", {31'd0, acc}, 1);
      while (mcyc < 256) idle();
      check("t2_duty", {24'd0, da1}, 64);
      check("t2_pstart", {31'd0, ps1}, 1);
      count_period(hi, fh, lh, ll);
      check("t2_high", hi, 64);
      check("t2_first_hi", fh, 0);
      check("t2_last_hi", lh, 63);

      // Back-pressure: 10 then 20 back-to-back.
      for (int i = 0; i < 20; i++) idle();
      cycle(1'b1, 8'd10, acc);
      check("t3_acc10", {31'd0, acc}, 1);
      acc = 1'b0;
      last_bnd = 1'b0;
      for (int i = 0; i < 300 && !acc; i++) begin
         last_bnd = (mcyc % 256 == 255);
         cycle(1'b1, 8'd20, acc);
      end
      check("t3_acc20", {31'd0, acc}, 1);
      check("t3_acc_at_bnd", {31'd0, last_bnd}, 1);
      check("t3_duty10", {24'd0, da1}, 10);
      to_period_start();
      check("t3_duty20", {24'd0, da1}, 20);

      // Extremes: duty 0 and duty 255.
      cycle(1'b1, 8'd0, acc);
      to_period_start();
      count_period(hi, fh, lh, ll);
      check("t4_zero_high", hi, 0);
      cycle(1'b1, 8'd255, acc);
      to_period_start();
      count_period(hi, fh, lh, ll);
      check("t4_full_high", hi, 255);
      check("t4_full_low_at", ll, 255);

      // Reset mid-operation with active 200 and pending 50.
      cycle(1'b1, 8'd200, acc);
      to_period_start();
      check("t6_duty200", {24'd0, da1}, 200);
      cycle(1'b1, 8'd50, acc);
      check("t6_acc50", {31'd0, acc}, 1);
      while (mcyc % 256 != 100) idle();
      rst_n = 1'b0;
      #1;
      check("t6_async_duty", {24'd0, da1}, 0);
      check("t6_async_pwm", {31'd0, pwm1}, 0);
      check("t6_async_pstart", {31'd0, ps1}, 0);
      check("t6_async_ready", {31'd0, bus1.in_ready}, 1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mreset();

      // PRESCALE=4 instance: duty 128, period 1024 cycles; PRESCALE=1 instance idles.
      npulse = 0;
      hi4 = 0;
      for (int i = 0; i < 8; i++) pulses[i] = -1;
      for (int k = 0; k < 3100; k++) begin
         bus4.in_valid = (k == 0);
         bus4.in_data  = 8'd128;
         if (k == 0) check("t5_ready4", {31'd0, bus4.in_ready}, 1);
         idle();
         if (ps4) begin
            if (npulse < 8) pulses[npulse] = k;
            npulse++;
         end
         if (k >= 1024 && k < 2048 && pwm4) hi4++;
         if (k == 1022) check("t5_duty_before", {24'd0, da4}, 0);
         if (k == 1023) check("t5_duty_after", {24'd0, da4}, 128);
      end
      bus4.in_valid = 1'b0;
      check("t5_npulse", npulse, 3);
      check("t5_first_pulse", pulses[0], 1023);
      check("t5_spacing1", pulses[1] - pulses[0], 1024);
      check("t6_lost_pending", {24'd0, da1}, 0);
      check("t5_spacing2", pulses[2] - pulses[1], 1024);
      check("t5_high", hi4, 512);

      // Random traffic honouring the hold-while-stalled rule.
      hold = 1'b0;
      v = 1'b0;
      d = '0;
      for (int i = 0; i < 3000; i++) begin
         if (!hold) begin
            v = ($urandom_range(0, 3) == 0);
            d = 8'($urandom);
         end
         cycle(v, d, acc);
         hold = v && !acc;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
